// File: rtl/key_debounce_conditioner.sv
// Push-button conditioner: per-key 2-FF sync, stability-count debounce,
// press/release pulses and a long-press hold flag. Keys are independent.

module key_debounce_lane #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 50_000_000
) (
  input  logic clk_clk,
  input  logic reset_reset_n,
  input  logic key_raw_n,
  output logic key_db_n,
  output logic key_press,
  output logic key_release,
  output logic key_hold
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HCNT_MAX  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HCNT_PRE  = HW'(HOLD_CYCLES - 1);

  logic          s1, s2;
  logic [DW-1:0] dcnt;
  logic [HW-1:0] hcnt;
  logic          accept;
  logic          db_nxt;

  // Acceptance happens on the DEBOUNCE_CYCLES-th consecutive mismatching sample
  always_comb begin
    accept = (s2 != key_db_n) && (dcnt == DCNT_LAST);
    db_nxt = accept ? s2 : key_db_n;
  end

  // Two-flop synchronizer; idles high (released)
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= key_raw_n;
      s2 <= s1;
    end
  end

  // Stability counter; any agreeing sample aborts a pending change
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      dcnt        <= '0;
      key_db_n    <= 1'b1;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_press   <= accept & ~s2;
      key_release <= accept &  s2;
      key_db_n    <= db_nxt;
      if (s2 == key_db_n || accept) dcnt <= '0;
      else                          dcnt <= dcnt + 1'b1;
    end
  end

  // Hold timer: counts cycles with the debounced level low, saturating.
  // Clear looks at db_nxt so key_hold drops on the same edge as key_release.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      hcnt     <= '0;
      key_hold <= 1'b0;
    end else if (db_nxt) begin
      hcnt     <= '0;
      key_hold <= 1'b0;
    end else if (!key_db_n && hcnt != HCNT_MAX) begin
      hcnt <= hcnt + 1'b1;
      if (hcnt == HCNT_PRE) key_hold <= 1'b1;
    end
  end
endmodule

module key_debounce_conditioner #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 50_000_000
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [N_KEYS-1:0] key_raw_n,
  output logic [N_KEYS-1:0] key_db_n,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_hold
);
  for (genvar g = 0; g < N_KEYS; g++) begin : g_lane
    key_debounce_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES)
    ) u_lane (
      .clk_clk      (clk_clk),
      .reset_reset_n(reset_reset_n),
      .key_raw_n    (key_raw_n[g]),
      .key_db_n     (key_db_n[g]),
      .key_press    (key_press[g]),
      .key_release  (key_release[g]),
      .key_hold     (key_hold[g])
    );
  end
endmodule

// File: tb/tb_key_debounce_conditioner.sv
// Bench for key_debounce_conditioner: vector table, directed corner sequences
// and random stimulus, all checked each cycle against a history-window model.

module tb_key_debounce_conditioner;
  localparam int N = 4;
  localparam int D = 8;
  localparam int H = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] key_raw_n;
  logic [N-1:0] key_db_n, key_press, key_release, key_hold;

  int n_cmp = 0;
  int n_bad = 0;

  key_debounce_conditioner #(.N_KEYS(N), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H)) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .key_raw_n    (key_raw_n),
    .key_db_n     (key_db_n),
    .key_press    (key_press),
    .key_release  (key_release),
    .key_hold     (key_hold)
  );

  always #5 clk = ~clk;

  // Reference model: synced-sample delay line, window of last D synced
  // samples, debounced level and age since accepted press.
  logic [1:0]   m_sync [N];
  logic [D-1:0] m_hist [N];
  logic [N-1:0] m_db, m_press, m_rel, m_hold;
  int           m_age  [N];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_sync[i] = 2'b11;
      m_hist[i] = '1;
      m_age[i]  = 0;
    end
    m_db = '1; m_press = '0; m_rel = '0; m_hold = '0;
  endtask

  task automatic model_edge(input logic [N-1:0] r);
    logic s2u, flip;
    for (int i = 0; i < N; i++) begin
      s2u        = m_sync[i][1];
      m_sync[i]  = {m_sync[i][0], r[i]};
      m_hist[i]  = {m_hist[i][D-2:0], s2u};
      flip       = (m_hist[i] == {D{~m_db[i]}});
      m_press[i] = flip &  m_db[i];
      m_rel[i]   = flip & ~m_db[i];
      if (flip) begin
        m_db[i]  = ~m_db[i];
        m_age[i] = 0;
      end else if (!m_db[i] && m_age[i] < 1000) begin
        m_age[i]++;
      end
      m_hold[i] = !m_db[i] && (m_age[i] >= H);
    end
  endtask

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".db"},   key_db_n,    m_db);
    chk({tag, ".prs"},  key_press,   m_press);
    chk({tag, ".rel"},  key_release, m_rel);
    chk({tag, ".hold"}, key_hold,    m_hold);
  endtask

  // One clock: drive, clock, advance the model, sample 1 ns after the edge
  task automatic step(input logic [N-1:0] r, input string tag);
    key_raw_n = r;
    @(posedge clk);
    model_edge(r);
    #1;
    check_model(tag);
  endtask

  // Clock with fixed input until press(0)/release(1)/hold(2) of key k shows; -1 on timeout
  task automatic run_until(input logic [N-1:0] r, input int sel, input int k,
                           input int limit, input string tag, output int n);
    logic [N-1:0] sig;
    n = -1;
    for (int c = 1; c <= limit; c++) begin
      step(r, tag);
      sig = (sel == 0) ? key_press : (sel == 1) ? key_release : key_hold;
      if (sig[k]) begin
        n = c;
        break;
      end
    end
  endtask

  typedef struct {
    logic [N-1:0] raw;
    int           cyc;
    logic [N-1:0] db, prs, rel, hold;
  } vec_t;

  vec_t tbl [15];
  int   n;
  logic [N-1:0] lvl, r;

  initial begin
    // Startup with all keys held down, then single-key press/release, short glitch
    tbl[0]  = '{4'h0,  9, 4'hF, 4'h0, 4'h0, 4'h0};
    tbl[1]  = '{4'h0,  1, 4'h0, 4'hF, 4'h0, 4'h0};
    tbl[2]  = '{4'h0,  1, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[3]  = '{4'h0, 30, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[4]  = '{4'h0,  1, 4'h0, 4'h0, 4'h0, 4'hF};
    tbl[5]  = '{4'hF,  9, 4'h0, 4'h0, 4'h0, 4'hF};
    tbl[6]  = '{4'hF,  1, 4'hF, 4'h0, 4'hF, 4'h0};
    tbl[7]  = '{4'hF,  1, 4'hF, 4'h0, 4'h0, 4'h0};
    tbl[8]  = '{4'hE,  9, 4'hF, 4'h0, 4'h0, 4'h0};
    tbl[9]  = '{4'hE,  1, 4'hE, 4'h1, 4'h0, 4'h0};
    tbl[10] = '{4'hE,  1, 4'hE, 4'h0, 4'h0, 4'h0};
    tbl[11] = '{4'hF,  9, 4'hE, 4'h0, 4'h0, 4'h0};
    tbl[12] = '{4'hF,  1, 4'hF, 4'h0, 4'h1, 4'h0};
    tbl[13] = '{4'hB,  7, 4'hF, 4'h0, 4'h0, 4'h0};
    tbl[14] = '{4'hF, 12, 4'hF, 4'h0, 4'h0, 4'h0};

    // Reset with keys pressed
    rst_n = 1'b0;
    key_raw_n = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.db",   key_db_n,    4'hF);
    chk("rst.prs",  key_press,   4'h0);
    chk("rst.rel",  key_release, 4'h0);
    chk("rst.hold", key_hold,    4'h0);
    #2 rst_n = 1'b1;

    // Vector table
    for (int v = 0; v < 15; v++) begin
      for (int c = 0; c < tbl[v].cyc; c++) step(tbl[v].raw, "tbl");
      chk($sformatf("tbl%0d.db", v),   key_db_n,    tbl[v].db);
      chk($sformatf("tbl%0d.prs", v),  key_press,   tbl[v].prs);
      chk($sformatf("tbl%0d.rel", v),  key_release, tbl[v].rel);
      chk($sformatf("tbl%0d.hold", v), key_hold,    tbl[v].hold);
    end

    // Bounce on key1: toggles every 3 clocks, then settles pressed
    for (int c = 0; c < 40; c++) step(((c / 3) % 2 == 0) ? 4'hD : 4'hF, "bnc");
    chk("bnc.db_stable", key_db_n, 4'hF);
    run_until(4'hD, 0, 1, 20, "bnc", n);
    chk_int("bnc.latency", n, 10);
    step(4'hD, "bnc");
    chk("bnc.one_press", key_press, 4'h0);
    run_until(4'hF, 1, 1, 20, "bnc", n);
    chk_int("bnc.rel_latency", n, 10);

    // Long press on key3: hold 32 cycles after press, clears with release
    run_until(4'h7, 0, 3, 20, "hld", n);
    chk_int("hld.press_latency", n, 10);
    run_until(4'h7, 2, 3, 40, "hld", n);
    chk_int("hld.hold_delay", n, H);
    repeat (18) step(4'h7, "hld");
    chk("hld.still_held", key_hold, 4'h8);
    run_until(4'hF, 1, 3, 20, "hld", n);
    chk_int("hld.rel_latency", n, 10);
    chk("hld.cleared_with_rel", key_hold, 4'h0);

    // Reset mid-hold on key3 and mid-bounce on key0
    run_until(4'h7, 0, 3, 20, "rmh", n);
    chk_int("rmh.press_latency", n, 10);
    repeat (20) step(4'h7, "rmh");
    repeat (4)  step(4'h6, "rmh");
    #2 rst_n = 1'b0;
    #1;
    chk("rmh.db",   key_db_n,    4'hF);
    chk("rmh.prs",  key_press,   4'h0);
    chk("rmh.rel",  key_release, 4'h0);
    chk("rmh.hold", key_hold,    4'h0);
    model_reset();
    key_raw_n = 4'h7;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    run_until(4'h7, 0, 3, 20, "rmh", n);
    chk_int("rmh.repress_latency", n, 10);
    run_until(4'h7, 2, 3, 40, "rmh", n);
    chk_int("rmh.rehold_delay", n, H);
    repeat (12) step(4'hF, "rmh");

    // Random keying with bounce, every cycle against the model
    lvl = '1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 39) == 0) lvl[i] = ~lvl[i];
        r[i] = lvl[i] ^ ($urandom_range(0, 9) == 0);
      end
      step(r, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
